qsys_system_key_pio_in: RTL

//  Avalon-MM slave input PIO for the alarm-clock push-buttons; the read-side counterpart of the digit output ports.

---
 rtl/qsys_pio_pkg.sv | 13 +
 rtl/key_debounce.sv | 29 ++
 rtl/qsys_system_key_pio_in.sv | 106 ++++++++++
 3 files changed

// File: rtl/qsys_pio_pkg.sv
// Shared register map and edge-type encodings for the Qsys input PIO blocks.
package qsys_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_DIR     = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/key_debounce.sv
// One-bit debouncer: output follows input only after CYC consecutive cycles of disagreement.
module key_debounce #(
  parameter logic        RESET_BIT = 1'b1,
  parameter logic [15:0] CYC       = 16'd50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout
);

  logic [15:0] count_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= 16'd0;
      dout      <= RESET_BIT;
    end else if (din == dout) begin
      count_reg <= 16'd0;
    end else if (count_reg == CYC - 16'd1) begin
      // Input has differed for CYC cycles in a row: accept the new level.
      dout      <= din;
      count_reg <= 16'd0;
    end else begin
      count_reg <= count_reg + 16'd1;
    end
  end

endmodule

// File: rtl/qsys_system_key_pio_in.sv
// Avalon-MM input PIO for the alarm-clock keys: sync, optional debounce, sticky edge capture, irq.
// Define KEY_PIO_DEBOUNCE_EN to insert a per-bit debouncer between the synchroniser and the level register.
module qsys_system_key_pio_in
  import qsys_pio_pkg::*;
#(
  parameter int              WIDTH        = 4,
  parameter int              EDGE_TYPE    = EDGE_FALL,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b1}},
  parameter logic [15:0]     DEBOUNCE_CYC = 16'd50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read_n,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync1, sync2, lvl, lvl_d;
  logic [WIDTH-1:0] edge_det, edge_cap, irq_mask, cap_clr;
  logic [31:0]      rd_mux;
  logic             wr_en, rd_en;
  logic             unused_bits;

  assign wr_en       = chipselect & ~write_n;
  assign rd_en       = chipselect & ~read_n;
  assign unused_bits = &{1'b0, writedata, DEBOUNCE_CYC};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= RESET_VALUE;
      sync2 <= RESET_VALUE;
      lvl_d <= RESET_VALUE;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
      lvl_d <= lvl;
    end
  end

`ifdef KEY_PIO_DEBOUNCE_EN
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_debounce
      key_debounce #(
        .RESET_BIT (RESET_VALUE[gi]),
        .CYC       (DEBOUNCE_CYC)
      ) u_debounce (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (sync2[gi]),
        .dout    (lvl[gi])
      );
    end
  endgenerate
`else
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lvl <= RESET_VALUE;
    else          lvl <= sync2;
  end
`endif

  generate
    if (EDGE_TYPE == EDGE_RISE) begin : g_rise
      assign edge_det = lvl & ~lvl_d;
    end else if (EDGE_TYPE == EDGE_FALL) begin : g_fall
      assign edge_det = ~lvl & lvl_d;
    end else begin : g_any
      assign edge_det = lvl ^ lvl_d;
    end
  endgenerate

  always_comb begin
    cap_clr = '0;
    if (wr_en && address == ADDR_EDGECAP) cap_clr = writedata[WIDTH-1:0];
  end

  always_comb begin
    rd_mux = 32'd0;
    case (address)
      ADDR_DATA:    rd_mux[WIDTH-1:0] = lvl;
      ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irq_mask;
      ADDR_EDGECAP: rd_mux[WIDTH-1:0] = edge_cap;
      default:      rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask <= '0;
      edge_cap <= '0;
      readdata <= 32'd0;
      irq      <= 1'b0;
    end else begin
      if (wr_en && address == ADDR_IRQMASK) irq_mask <= writedata[WIDTH-1:0];
      // A new edge overrides a clear landing in the same cycle so no press is lost.
      edge_cap <= (edge_cap & ~cap_clr) | edge_det;
      irq      <= |(edge_cap & irq_mask);
      if (rd_en) readdata <= rd_mux;
    end
  end

endmodule
